cdb_slot_scheduler: RTL
=======================

// Module: cdb_slot_scheduler
// PURPOSE
//  Reservation-table scheduler for the single Common Data Bus. It grants issue to the int, mem,
//  mult and div units so that no two results reach the CDB in the same cycle.
//  It drives the per-cycle CDB owner code that the CDB output mux consumes.
//  Sits between the issue queues (requesters) and the CDB mux.
// PARAMETERS
//  LAT_INT   1  cycles from int grant to int result on the CDB (>=1)
//  LAT_MEM   1  cycles from mem grant to mem result on the CDB (>=1)
//  LAT_MULT  4  cycles from mult grant to mult result (pipelined; differs from every other LAT_*)
//  LAT_DIV   7  cycles from div grant to div result (non-pipelined; differs from every other LAT_*)
//  DEPTH     8  reservation slots, indices 0..DEPTH-1; DEPTH = max(LAT_*)+1
// PORTS
//  clk         in   1  rising-edge clock
//  rst         in   1  asynchronous reset, active-low
//  req_int     in   1  int issue queue has an instruction ready
//  req_mem     in   1  mem issue queue has an instruction ready
//  req_mult    in   1  mult issue queue has an instruction ready
//  req_div     in   1  div issue queue has an instruction ready
//  grant_int   out  1  int issues this cycle (combinational)
//  grant_mem   out  1  mem issues this cycle (combinational)
//  grant_mult  out 1  mult issues this cycle (combinational)
//  grant_div   out  1  div issues this cycle (combinational)
//  cdb_owner   out  3  current CDB owner: 0 empty, 1 int, 2 mem, 3 mult, 4 div (registered)
//  cdb_valid   out  1  cdb_owner != 0
//  div_busy    out  1  divider occupied (registered)
// BEHAVIOUR
//  - Table slot[k] (3b code) holds the owner of the CDB k cycles from now; cdb_owner = slot[0].
//  - Every posedge: slot[k] <= slot[k+1]; slot[DEPTH-1] <= 0. Each granted unit U then writes
//    its code into slot[LAT_U-1] of the shifted table.
//    Result: the CDB owner is U exactly LAT_U cycles after the grant.
//  - Unit U is free this cycle iff slot[LAT_U]==0. U is granted iff req_U, U is free,
//    no higher-priority grant claims the same slot, and (for div) !div_busy.
//  - Priority is DIV > MULT > {INT,MEM}.
//  - If LAT_INT==LAT_MEM and both request a free slot, they share it round-robin. A 1-bit rr_ptr
//    (reset 0 = int first) toggles only when one of the two wins such a conflict.
//  - A grant is never asserted without its req. A requester holds req until it sees a grant;
//    the transfer happens on the cycle where req & grant are both high.
//  - At most one write per slot per cycle. Distinct latencies never collide; the int/mem
//    collision is resolved as above.
//  - div_busy: a counter loads LAT_DIV-1 on grant_div and decrements to 0.
//    div_busy = (cnt!=0), so a second div is granted no sooner than LAT_DIV cycles after the first.
//  - Reset (rst=0, async): every slot, cnt and rr_ptr are cleared to 0, so cdb_owner=0,
//    cdb_valid=0 and div_busy=0. All grants are forced to 0 while rst=0.
//    Reservations in flight are discarded.
//  - Release of reset is synchronous to clk. The first grant is possible in the cycle after
//    rst rises.
//  - A slot near the end of the table (index > every LAT_U) is always written 0 and never read
//    for grants. This is legal.
// TESTING
//  1. req_int=1 for one cycle at t0 (LAT_INT=1) -> grant_int=1 at t0; cdb_owner=1 at t0+1 only.
//  2. req_mult at t0, req_int held -> grant_mult at t0. grant_int is 0 at t0+3 (slot 1 holds
//     mult) and 1 at all other cycles. cdb_owner=3 at t0+4.
//  3. req_div held 20 cycles -> grants at t0, t0+7 and t0+14; div_busy is high 6 of every
//     7 cycles; cdb_owner=4 at t0+7, t0+14 and t0+21.
//  4. req_int and req_mem both held, LAT 1/1 -> grants alternate int, mem, int, mem starting
//     with int; cdb_owner alternates 1, 2, ...; never both granted in one cycle.
//  5. All four req held 30 cycles -> scoreboard: every grant yields exactly one cdb_owner
//     match at +LAT_U; never two results in one cycle.
//  6. Assert rst=0 mid-stream with mult/div in flight -> cdb_owner=0, div_busy=0, grants=0
//     immediately (async); after release, req_div is granted next cycle.

Source files
------------

// File: rtl/cdb_slot_scheduler.sv
// cdb_slot_scheduler
//   Grants issue to the int, mem, mult and div units so that no two results
//   land on the single Common Data Bus in the same cycle. A shift-register
//   reservation table records, for each upcoming cycle, which unit owns the
//   CDB. Slot 0 is the current owner, and the CDB output mux consumes it.
//
// Ports
//   clk                     rising-edge clock
//   rst                     asynchronous reset, active-low
//   req_int/mem/mult/div    issue-queue requests (held until granted)
//   grant_int/mem/mult/div  combinational issue grants
//   cdb_owner[2:0]          current CDB owner: 0 none, 1 int, 2 mem, 3 mult, 4 div
//   cdb_valid               cdb_owner != 0
//   div_busy                non-pipelined divider occupied
module cdb_slot_scheduler #(
  parameter int LAT_INT  = 1,
  parameter int LAT_MEM  = 1,
  parameter int LAT_MULT = 4,
  parameter int LAT_DIV  = 7,
  parameter int DEPTH    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_int,
  input  logic       req_mem,
  input  logic       req_mult,
  input  logic       req_div,
  output logic       grant_int,
  output logic       grant_mem,
  output logic       grant_mult,
  output logic       grant_div,
  output logic [2:0] cdb_owner,
  output logic       cdb_valid,
  output logic       div_busy
);

  typedef enum logic [2:0] {
    OWN_NONE = 3'd0,
    OWN_INT  = 3'd1,
    OWN_MEM  = 3'd2,
    OWN_MULT = 3'd3,
    OWN_DIV  = 3'd4
  } owner_e;

  localparam int CW = $clog2(LAT_DIV + 1);

  logic [DEPTH-1:0][2:0] slot_q, slot_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rr_q, rr_d;

  logic free_int, free_mem, free_mult, free_div;
  logic elig_int, elig_mem;

  always_comb begin
    // A unit is free when the slot its result would occupy is empty. Slot
    // LAT_U is examined because the table shifts by one before the write.
    free_int  = (slot_q[LAT_INT]  == OWN_NONE);
    free_mem  = (slot_q[LAT_MEM]  == OWN_NONE);
    free_mult = (slot_q[LAT_MULT] == OWN_NONE);
    free_div  = (slot_q[LAT_DIV]  == OWN_NONE);

    // Priority DIV > MULT > {INT, MEM}. A lower-priority unit is blocked
    // only if a higher grant claims the same slot (equal latencies).
    grant_div  = rst & req_div & free_div & (cnt_q == '0);
    grant_mult = rst & req_mult & free_mult
                 & ~(grant_div & (LAT_DIV == LAT_MULT));
    elig_int   = rst & req_int & free_int
                 & ~(grant_div & (LAT_DIV == LAT_INT))
                 & ~(grant_mult & (LAT_MULT == LAT_INT));
    elig_mem   = rst & req_mem & free_mem
                 & ~(grant_div & (LAT_DIV == LAT_MEM))
                 & ~(grant_mult & (LAT_MULT == LAT_MEM));

    grant_int = elig_int;
    grant_mem = elig_mem;
    rr_d      = rr_q;
    // Round-robin applies only if int and mem compete for one slot. rr_q=0
    // favours int, and the pointer moves only when the conflict occurs.
    if ((LAT_INT == LAT_MEM) && elig_int && elig_mem) begin
      grant_int = ~rr_q;
      grant_mem = rr_q;
      rr_d      = ~rr_q;
    end

    slot_d = {OWN_NONE, slot_q[DEPTH-1:1]};
    if (grant_int)  slot_d[LAT_INT-1]  = OWN_INT;
    if (grant_mem)  slot_d[LAT_MEM-1]  = OWN_MEM;
    if (grant_mult) slot_d[LAT_MULT-1] = OWN_MULT;
    if (grant_div)  slot_d[LAT_DIV-1]  = OWN_DIV;

    if (grant_div) begin
      cnt_d = CW'(LAT_DIV - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_q <= '0;
      cnt_q  <= '0;
      rr_q   <= 1'b0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      rr_q   <= rr_d;
    end
  end

  assign cdb_owner = slot_q[0];
  assign cdb_valid = |slot_q[0];
  assign div_busy  = |cnt_q;

endmodule
